mcycle_muldiv: RTL and testbench

Multi-cycle unsigned multiply/divide unit that executes the long-latency arithmetic requested by the control unit. It sits directly downstream of the control unit's `M_Start`/`MCycleOp` outputs. Its `Done` output feeds back as the control unit's `done` input, which stalls the PC and register write-back until the result is ready. Results are consumed by the write-back mux: `Result1` is written through the `MWrite` path.

---
 rtl/mcycle_muldiv_if.sv | 35 +++
 rtl/mcycle_muldiv.sv | 147 ++++++++++++++
 tb/tb_mcycle_muldiv.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mcycle_muldiv_if.sv
// rtl/mcycle_muldiv_if.sv - request/result bundle between the control unit and the multi-cycle mul/div unit
//
// Signals:
//   Start     control -> unit  level request, sampled only while the unit is idle
//   MCycleOp  control -> unit  0 = multiply, 1 = divide
//   Operand1  control -> unit  multiplicand / dividend
//   Operand2  control -> unit  multiplier / divisor
//   Result1   unit -> control  product low half / quotient
//   Result2   unit -> control  product high half / remainder
//   Busy      unit -> control  high while iterating
//   Done      unit -> control  one-cycle completion pulse
// Modports: master = control unit side, slave = mul/div unit side.

interface mcycle_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_muldiv.sv
// rtl/mcycle_muldiv.sv - multi-cycle unsigned shift-add multiplier / restoring divider
//
// Ports:
//   CLK    single clock, all state on the rising edge
//   RESET  synchronous, active-high; aborts any operation and clears results
//   bus    mcycle_muldiv_if.slave: Start/MCycleOp/Operand1/Operand2 in,
//          Result1/Result2/Busy/Done out
// One operand bit is consumed per RUN cycle, so an operation takes WIDTH
// RUN cycles followed by one DONE cycle.

module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    mcycle_muldiv_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res1_q, res1_d;
    logic [WIDTH-1:0]   res2_q, res2_d;

    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_acc;
    logic [2*WIDTH-1:0] step_acc;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held Start cannot relaunch
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.Busy = (state_q == S_RUN);
        bus.Done = (state_q == S_DONE);
    end

    assign bus.Result1 = res1_q;
    assign bus.Result2 = res2_q;

    // Datapath. The accumulator starts cleared for both operations:
    //  - multiply: the multiplier is shifted right out of op2_q, LSB first, and
    //    the accumulator shifts the product in from the top.
    //  - divide: the dividend is shifted left out of op1_q, MSB first, into the
    //    remainder (upper half); quotient bits enter at the bottom of the lower half.
    always_comb begin
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (op2_q[0] ? op1_q : {WIDTH{1'b0}})};
        mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder is always below the divisor, so a WIDTH+1-bit subtract
        // gives a reliable sign bit; a zero divisor yields all-ones quotient.
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], op1_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, op2_q};
        div_rem  = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_acc  = {div_rem, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

        step_acc = op_q ? div_acc : mul_acc;

        cnt_d  = cnt_q;
        op_d   = op_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        acc_d  = acc_q;
        res1_d = res1_q;
        res2_d = res2_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    op_d  = bus.MCycleOp;
                    op1_d = bus.Operand1;
                    op2_d = bus.Operand2;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                cnt_d = last_iter ? '0 : cnt_q + CNT_W'(1);
                if (op_q) begin
                    op1_d = op1_q << 1;
                end else begin
                    op2_d = op2_q >> 1;
                end
                if (last_iter) begin
                    res1_d = step_acc[WIDTH-1:0];
                    res2_d = step_acc[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q  <= '0;
            op_q   <= 1'b0;
            op1_q  <= '0;
            op2_q  <= '0;
            acc_q  <= '0;
            res1_q <= '0;
            res2_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            acc_q  <= acc_d;
            res1_q <= res1_d;
            res2_q <= res2_d;
        end
    end
endmodule

// File: tb/tb_mcycle_muldiv.sv
// tb/tb_mcycle_muldiv.sv - scoreboard testbench for mcycle_muldiv

module tb_mcycle_muldiv;
    localparam int W = 32;

    logic clk;
    logic rst;

    mcycle_muldiv_if #(.WIDTH(W)) bus ();

    mcycle_muldiv #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_ops    = 0;

    always @(negedge clk) begin
        if (!rst && bus.Done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [63:0] p;
        if (!op) begin
            p    = 64'(a) * 64'(b);
            e.r1 = p[W-1:0];
            e.r2 = p[63:32];
        end else if (b == '0) begin
            e.r1 = '1;
            e.r2 = a;
        end else begin
            e.r1 = a / b;
            e.r2 = a % b;
        end
        return e;
    endfunction

    // Launch one operation; Start stays high until Done is seen (and through the
    // DONE cycle when hold is set). Operands are scrambled after acceptance.
    task automatic do_op(input string tag, input bit op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
        int cyc;
        exp_t e;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        @(posedge clk);
        #1;
        bus.Operand1 = $urandom;
        bus.Operand2 = $urandom;
        bus.MCycleOp = ~op;
        check({tag, "_busy_first"}, 64'(bus.Busy), 64'd1);
        cyc = 0;
        while (!bus.Done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(W));
        check({tag, "_busy_in_done"}, 64'(bus.Busy), 64'd0);
        n_ops++;
        e = exp_q.pop_front();
        check({tag, "_r1"}, 64'(bus.Result1), 64'(e.r1));
        check({tag, "_r2"}, 64'(bus.Result2), 64'(e.r2));
        if (!hold) bus.Start = 1'b0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        check({tag, "_done_pulse"}, 64'(bus.Done), 64'd0);
        check({tag, "_idle"}, 64'(bus.Busy), 64'd0);
        check({tag, "_hold_r1"}, 64'(bus.Result1), 64'(e.r1));
    endtask

    initial begin
        rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.MCycleOp = 1'b0;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_r1", 64'(bus.Result1), 64'd0);
        check("rst_r2", 64'(bus.Result2), 64'd0);
        rst = 1'b0;

        do_op("mul_7x6",  1'b0, 32'd7, 32'd6, 1'b0);
        do_op("mul_full", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0);
        do_op("div_msb_1", 1'b1, 32'h8000_0000, 32'd1, 1'b0);
        do_op("div_by_0", 1'b1, 32'd5, 32'd0, 1'b0);

        // Start held across DONE, then an immediate back-to-back request
        do_op("held", 1'b0, 32'd1234, 32'd5678, 1'b1);
        @(posedge clk);
        #1;
        check("held_no_relaunch", 64'(bus.Busy), 64'd0);
        do_op("b2b", 1'b1, 32'hDEAD_BEEF, 32'd17, 1'b0);
        do_op("b2b_next", 1'b1, 32'h0000_0003, 32'h0000_0009, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op("rand_mul", 1'b0, $urandom, $urandom, 1'b0);
            do_op("rand_div", 1'b1, $urandom, $urandom_range(1, 1000), 1'b0);
        end

        // Reset asserted so it is sampled at edge 10 of RUN
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.MCycleOp = 1'b0;
        bus.Operand1 = 32'd99;
        bus.Operand2 = 32'd77;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy_before", 64'(bus.Busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", 64'(bus.Busy), 64'd0);
        check("mid_rst_done", 64'(bus.Done), 64'd0);
        check("mid_rst_r1", 64'(bus.Result1), 64'd0);
        check("mid_rst_r2", 64'(bus.Result2), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(bus.Done), 64'd0);

        do_op("mul_3x4", 1'b0, 32'd3, 32'd4, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("done_pulse_count", 64'(n_done), 64'(n_ops));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
